// File: rtl/rr_mux_select_sequencer_if.sv
// -----------------------------------------------------------------------------
// rr_mux_select_sequencer_if
// Bundle between request sources and the select sequencer.
//   req       : per-source request, level-sensitive (sources -> sequencer)
//   sel       : registered select for the downstream 4:1 mux
//   grant     : one-hot grant, zero when nobody owns the mux
//   sel_valid : high while sel points at an active owner
//   dwell     : cycles the current owner has held its grant
// Modports: master = request side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface rr_mux_select_sequencer_if #(
  parameter int MAX_HOLD = 16
);
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [3:0]    req;
  logic [1:0]    sel;
  logic [3:0]    grant;
  logic          sel_valid;
  logic [CW-1:0] dwell;

  modport master (output req, input sel, grant, sel_valid, dwell);
  modport slave  (input req, output sel, grant, sel_valid, dwell);
endinterface

// File: rtl/rr_mux_select_sequencer.sv
// -----------------------------------------------------------------------------
// rr_mux_select_sequencer
// Round-robin arbiter that drives the 2-bit select of a four_to_one_mux.
// Each grant is held for at least MIN_HOLD cycles and every hand-over passes
// through one IDLE cycle (break-before-make) with sel frozen, so the mux
// input never chatters.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : rr_mux_select_sequencer_if.slave (req in; sel/grant/sel_valid/dwell out)
//
// Parameters:
//   MIN_HOLD : minimum cycles a grant is held (>= 1)
//   MAX_HOLD : dwell saturation value; pre-emption threshold when enabled
//
// Optional feature (macro SEL_PREEMPT_EN): an owner that has held the grant
// for MAX_HOLD cycles is released as soon as any other source is requesting.
// -----------------------------------------------------------------------------
module rr_mux_select_sequencer #(
  parameter int MIN_HOLD = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  rr_mux_select_sequencer_if.slave        bus
);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        r_state;
  logic [1:0]    r_sel;
  logic [3:0]    r_grant;
  logic          r_sel_valid;
  logic [CW-1:0] r_dwell;
  logic [1:0]    r_last;       // most recent owner; scan starts just after it

  logic [1:0]    w_win;
  logic          w_found;
  logic          w_release;

  // Round-robin pick: first set request scanning from r_last+1 with wrap.
  // k=4 wraps back to r_last itself so a lone requester is never starved.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    w_win   = r_last;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && bus.req[r_last + 2'(k)]) begin
        w_win   = r_last + 2'(k);
        w_found = 1'b1;
      end
    end
  end

  // Release once the minimum dwell is met and the owner has let go.
  always_comb begin
    w_release = (r_dwell >= CW'(MIN_HOLD)) && !bus.req[r_sel];
`ifdef SEL_PREEMPT_EN
    if ((r_dwell >= CW'(MAX_HOLD)) && ((bus.req & ~r_grant) != 4'b0000))
      w_release = 1'b1;
`else
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all state here is plain flops, so everything is cleared by the
    // async reset, and sequential state is written with non-blocking (<=)
    // assignments only, so every flop samples pre-edge values.
    if (rst) begin
      r_state     <= IDLE;
      r_sel       <= 2'd0;
      r_grant     <= 4'b0000;
      r_sel_valid <= 1'b0;
      r_dwell     <= '0;
      r_last      <= 2'd3;
    end else begin
      case (r_state)
        IDLE: begin
          if (|bus.req) begin
            r_sel       <= w_win;
            r_grant     <= 4'b0001 << w_win;
            r_sel_valid <= 1'b1;
            r_dwell     <= CW'(1);
            r_last      <= w_win;
            r_state     <= OWN;
          end
        end
        OWN: begin
          if (w_release) begin
            // sel is left alone so the mux input stays put through the gap.
            r_grant     <= 4'b0000;
            r_sel_valid <= 1'b0;
            r_dwell     <= '0;
            r_state     <= IDLE;
          end else if (r_dwell != CW'(MAX_HOLD)) begin
            r_dwell <= r_dwell + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sel       = r_sel;
  assign bus.grant     = r_grant;
  assign bus.sel_valid = r_sel_valid;
  assign bus.dwell     = r_dwell;

endmodule
